tx_ctrl_scheduler: RTL and testbench

- Transmit-side frame-header scheduler for the RIFL link.
- At every frame boundary it picks the 18-bit header for the next outgoing frame: a data frame, an idle frame, a PAUSE key burst or a RETRANS key burst.
- It produces the consecutive-key bursts and the regular-frame recovery runs that the far-end receive controller needs before it asserts or clears its pause and retransmit requests.
- It sits between the local receive path (buffer-full and CRC-error indications), the remote request outputs of the local receive controller, and the TX frame buffer/framer.

---
 rtl/tx_ctrl_scheduler.sv | 177 +++++++++++++++++
 tb/tb_tx_ctrl_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tx_ctrl_scheduler.sv
// tx_ctrl_scheduler
// Transmit-side frame-header scheduler for the RIFL link. At every frame
// boundary (sof) it picks the 18-bit header of the next outgoing frame:
// data, idle, a PAUSE key burst or a RETRANS key burst. It also produces the
// regular-frame recovery run after each burst, and a replay pulse towards the
// TX buffer when the far end asks for a replay.
//
// Ports:
//   clk            - clock
//   rst_n          - asynchronous active-low reset
//   sof            - frame-boundary strobe, one cycle per frame
//   link_up        - TX/RX lane alignment achieved
//   local_pause    - local RX buffer above high watermark (level)
//   local_retrans  - local CRC error detected (pulse)
//   remote_pause   - far end requests pause (level)
//   remote_retrans - far end requests replay (level)
//   data_valid     - TX buffer holds a frame
//   data_hdr       - header payload of the head frame
//   data_ready     - pop strobe to the TX buffer (combinational)
//   code           - header of the frame starting after the current sof
//   replay_start   - one-cycle rewind pulse to the TX buffer
//   ctrl_state     - current state (NORMAL=0, PAUSE=1, RETRANS=2, RESUME=3)

module tx_ctrl_scheduler #(
  parameter int PAUSE_MIN   = 12,
  parameter int RETRANS_LEN = 12,
  parameter int RESUME_LEN  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        link_up,
  input  logic        local_pause,
  input  logic        local_retrans,
  input  logic        remote_pause,
  input  logic        remote_retrans,
  input  logic        data_valid,
  input  logic [15:0] data_hdr,
  output logic        data_ready,
  output logic [17:0] code,
  output logic        replay_start,
  output logic [1:0]  ctrl_state
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RETRANS = 2'd2,
    ST_RESUME  = 2'd3
  } state_t;

  localparam logic [17:0] CODE_IDLE    = {2'b10, 16'h0001};
  localparam logic [17:0] CODE_PAUSE   = {2'b10, 16'h0010};
  localparam logic [17:0] CODE_RETRANS = {2'b10, 16'h1000};

  // Counter value seen on the sof that emits the last frame of a run.
  localparam logic [5:0] PAUSE_LAST   = 6'(PAUSE_MIN - 1);
  localparam logic [5:0] RETRANS_LAST = 6'(RETRANS_LEN - 1);
  localparam logic [5:0] RESUME_LAST  = 6'(RESUME_LEN - 1);

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        pend_reg, pend_next;
  logic [17:0] code_reg, code_next;
  logic        rr_prev_reg;
  logic        replay_reg;

  logic       retrans_req;
  logic       data_ok;
  logic [5:0] cnt_inc;

  // A pulse coinciding with the sof counts as pending on that same sof.
  assign retrans_req = pend_reg | local_retrans;
  assign cnt_inc     = (cnt_reg == 6'd63) ? cnt_reg : cnt_reg + 6'd1;
  assign data_ok     = sof && link_up && data_valid && !remote_pause;

  // State register (plus counter, pending flag, code and replay edge logic)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_NORMAL;
      cnt_reg     <= 6'd0;
      pend_reg    <= 1'b0;
      code_reg    <= CODE_IDLE;
      rr_prev_reg <= 1'b0;
      replay_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      code_reg    <= code_next;
      // Edge memory is held at zero while the link is down so a request
      // already high at link-up still produces a replay pulse.
      rr_prev_reg <= link_up & remote_retrans;
      replay_reg  <= link_up & remote_retrans & ~rr_prev_reg;
    end
  end

  // Next-state logic. The code emitted on a sof belongs to the state the
  // scheduler is in on that sof; a transition takes effect from the next frame.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    // Pulses arriving during a RETRANS burst are already covered by it.
    pend_next  = pend_reg | (local_retrans && (state_reg != ST_RETRANS));
    if (!link_up) begin
      state_next = ST_NORMAL;
      cnt_next   = 6'd0;
      pend_next  = 1'b0;
    end else if (sof) begin
      case (state_reg)
        ST_NORMAL: begin
          if (retrans_req) begin
            state_next = ST_RETRANS;
            cnt_next   = 6'd0;
          end else if (local_pause) begin
            state_next = ST_PAUSE;
            cnt_next   = 6'd0;
          end
        end
        ST_PAUSE: begin
          if ((cnt_reg >= PAUSE_LAST) && !local_pause) begin
            state_next = retrans_req ? ST_RETRANS : ST_RESUME;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_RETRANS: begin
          if (cnt_reg >= RETRANS_LAST) begin
            state_next = ST_RESUME;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin // ST_RESUME
          if (retrans_req) begin
            state_next = ST_RETRANS;
            cnt_next   = 6'd0;
          end else if (local_pause) begin
            state_next = ST_PAUSE;
            cnt_next   = 6'd0;
          end else if (cnt_reg >= RESUME_LAST) begin
            state_next = ST_NORMAL;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      endcase
      // Entering (or restarting) a RETRANS burst consumes the request.
      if ((state_next == ST_RETRANS) && (state_reg != ST_RETRANS || cnt_next == 6'd0)
          && retrans_req && (state_reg != ST_RETRANS))
        pend_next = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    data_ready = data_ok && ((state_reg == ST_NORMAL) || (state_reg == ST_RESUME));
    code_next  = code_reg;
    if (!link_up) begin
      code_next = CODE_IDLE;
    end else if (sof) begin
      case (state_reg)
        ST_PAUSE:   code_next = CODE_PAUSE;
        ST_RETRANS: code_next = CODE_RETRANS;
        default:    code_next = data_ok ? {2'b01, data_hdr} : CODE_IDLE;
      endcase
    end
  end

  assign code         = code_reg;
  assign replay_start = replay_reg;
  assign ctrl_state   = state_reg;

endmodule

// File: tb/tb_tx_ctrl_scheduler.sv
// Directed testbench for tx_ctrl_scheduler. Each frame is two clock cycles:
// a sof cycle followed by one quiet cycle. data_ready is sampled inside the
// sof cycle, code and ctrl_state one half-cycle after the sof edge.

module tb_tx_ctrl_scheduler;

  localparam logic [17:0] IDLE_C = 18'h20001;
  localparam logic [17:0] PAUS_C = 18'h20010;
  localparam logic [17:0] RETR_C = 18'h21000;
  localparam logic [17:0] DATA_C = {2'b01, 16'hA5A5};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof, link_up, local_pause, local_retrans;
  logic        remote_pause, remote_retrans, data_valid;
  logic [15:0] data_hdr;
  logic        data_ready;
  logic [17:0] code;
  logic        replay_start;
  logic [1:0]  ctrl_state;

  int checks = 0;
  int errors = 0;

  tx_ctrl_scheduler #(.PAUSE_MIN(12), .RETRANS_LEN(12), .RESUME_LEN(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sof            (sof),
    .link_up        (link_up),
    .local_pause    (local_pause),
    .local_retrans  (local_retrans),
    .remote_pause   (remote_pause),
    .remote_retrans (remote_retrans),
    .data_valid     (data_valid),
    .data_hdr       (data_hdr),
    .data_ready     (data_ready),
    .code           (code),
    .replay_start   (replay_start),
    .ctrl_state     (ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: sof (optionally with a coincident local_retrans), then check
  // data_ready during sof and code/ctrl_state after the edge.
  task automatic frame(input logic [17:0] exp_code, input logic exp_dr,
                       input logic [1:0] exp_st, input string tag,
                       input logic retr = 1'b0);
    @(negedge clk);
    sof = 1'b1;
    local_retrans = retr;
    #1;
    check({tag, "/data_ready"}, {31'd0, data_ready}, {31'd0, exp_dr});
    @(negedge clk);
    sof = 1'b0;
    local_retrans = 1'b0;
    check({tag, "/code"}, {14'd0, code}, {14'd0, exp_code});
    check({tag, "/state"}, {30'd0, ctrl_state}, {30'd0, exp_st});
    $display("frame %-12s code=%05h state=%0d data_ready=%0b", tag, code, ctrl_state, exp_dr);
  endtask

  task automatic pulse_retrans();
    @(negedge clk);
    local_retrans = 1'b1;
    @(negedge clk);
    local_retrans = 1'b0;
  endtask

  // 19 RESUME data frames followed by the one that returns to NORMAL.
  task automatic resume_run(input string tag);
    for (int i = 0; i < 19; i++) frame(DATA_C, 1'b1, 2'd3, tag);
    frame(DATA_C, 1'b1, 2'd0, {tag, "_end"});
  endtask

  initial begin
    rst_n = 1'b0; sof = 1'b0; link_up = 1'b0; local_pause = 1'b0;
    local_retrans = 1'b0; remote_pause = 1'b0; remote_retrans = 1'b0;
    data_valid = 1'b0; data_hdr = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/code", {14'd0, code}, {14'd0, IDLE_C});
    check("rst/state", {30'd0, ctrl_state}, 32'd0);
    check("rst/replay", {31'd0, replay_start}, 32'd0);
    check("rst/data_ready", {31'd0, data_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    link_up = 1'b1;
    data_valid = 1'b1;

    // Four data frames with distinct headers
    for (int i = 0; i < 4; i++) begin
      data_hdr = 16'h1234 + 16'(i * 16'h1111);
      frame({2'b01, 16'h1234 + 16'(i * 16'h1111)}, 1'b1, 2'd0, "data");
    end
    data_hdr = 16'hA5A5;

    // local_pause held 3 frames: 12 PAUSE codes, 20 regular, NORMAL
    local_pause = 1'b1;
    frame(DATA_C, 1'b1, 2'd1, "p3_entry");
    frame(PAUS_C, 1'b0, 2'd1, "p3_pause");
    frame(PAUS_C, 1'b0, 2'd1, "p3_pause");
    local_pause = 1'b0;
    for (int i = 0; i < 9; i++) frame(PAUS_C, 1'b0, 2'd1, "p3_pause");
    frame(PAUS_C, 1'b0, 2'd3, "p3_last");
    resume_run("p3_resume");
    frame(DATA_C, 1'b1, 2'd0, "p3_normal");

    // local_pause held 30 frames: 30 PAUSE codes, then RESUME
    local_pause = 1'b1;
    frame(DATA_C, 1'b1, 2'd1, "p30_entry");
    for (int i = 0; i < 29; i++) frame(PAUS_C, 1'b0, 2'd1, "p30_pause");
    local_pause = 1'b0;
    frame(PAUS_C, 1'b0, 2'd3, "p30_last");
    resume_run("p30_resume");

    // local_retrans pulse: 12 RETRANS, restart in RESUME frame 5
    pulse_retrans();
    frame(DATA_C, 1'b1, 2'd2, "r1_entry");
    for (int i = 0; i < 11; i++) frame(RETR_C, 1'b0, 2'd2, "r1_burst");
    frame(RETR_C, 1'b0, 2'd3, "r1_last");
    for (int i = 0; i < 5; i++) frame(DATA_C, 1'b1, 2'd3, "r1_resume");
    pulse_retrans();
    frame(DATA_C, 1'b1, 2'd2, "r2_entry");
    for (int i = 0; i < 3; i++) frame(RETR_C, 1'b0, 2'd2, "r2_burst");
    pulse_retrans();  // absorbed by the running burst
    for (int i = 0; i < 8; i++) frame(RETR_C, 1'b0, 2'd2, "r2_burst");
    frame(RETR_C, 1'b0, 2'd3, "r2_last");
    resume_run("r2_resume");

    // local_retrans and local_pause on the same sof
    local_pause = 1'b1;
    frame(DATA_C, 1'b1, 2'd2, "sim_entry", 1'b1);
    for (int i = 0; i < 11; i++) frame(RETR_C, 1'b0, 2'd2, "sim_burst");
    frame(RETR_C, 1'b0, 2'd3, "sim_rlast");
    frame(DATA_C, 1'b1, 2'd1, "sim_topause");
    local_pause = 1'b0;
    for (int i = 0; i < 11; i++) frame(PAUS_C, 1'b0, 2'd1, "sim_pause");
    frame(PAUS_C, 1'b0, 2'd3, "sim_plast");
    resume_run("sim_resume");

    // remote_retrans rise: exactly one replay_start pulse
    @(negedge clk);
    check("replay/idle", {31'd0, replay_start}, 32'd0);
    remote_retrans = 1'b1;
    @(posedge clk); #1;
    check("replay/pulse", {31'd0, replay_start}, 32'd1);
    $display("replay_start pulse observed=%0b", replay_start);
    @(posedge clk); #1;
    check("replay/after", {31'd0, replay_start}, 32'd0);
    @(negedge clk);
    remote_retrans = 1'b0;

    // remote_pause: idle only, no pops
    remote_pause = 1'b1;
    frame(IDLE_C, 1'b0, 2'd0, "rpause");
    frame(IDLE_C, 1'b0, 2'd0, "rpause");
    remote_pause = 1'b0;

    // link_up drop in the middle of a RETRANS burst
    frame(DATA_C, 1'b1, 2'd2, "ld_entry", 1'b1);
    for (int i = 0; i < 3; i++) frame(RETR_C, 1'b0, 2'd2, "ld_burst");
    @(negedge clk);
    link_up = 1'b0;
    @(posedge clk); #1;
    check("ld/code", {14'd0, code}, {14'd0, IDLE_C});
    check("ld/state", {30'd0, ctrl_state}, 32'd0);
    $display("link drop code=%05h state=%0d", code, ctrl_state);
    frame(IDLE_C, 1'b0, 2'd0, "ld_down");
    link_up = 1'b1;
    frame(DATA_C, 1'b1, 2'd0, "ld_up");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
